safe_zone_round: RTL and testbench

- Level and round engine on the far side of the game-status handshake. It receives the regenerate-level request and the game-running qualifier.
- It returns generation-done (ready), round-ended and round-won.
- On each regenerate it places a square safe zone at a pseudo-random on-screen position. It then runs a pausable round timer and judges at expiry whether the player is inside the zone.
- It sits between the game-status controller and the renderer/player-position logic.

---
 rtl/safe_zone_round.sv | 129 ++++++++++++
 tb/tb_safe_zone_round.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/safe_zone_round.sv
// ============================================================
// safe_zone_round: safe-zone level generator and round timer
// Revision 1.0
// ============================================================
`default_nettype none

module safe_zone_round #(
   parameter int          SCREEN_W    = 640,
   parameter int          SCREEN_H    = 480,
   parameter int          ZONE_SIZE   = 64,
   parameter int          ROUND_TICKS = 300,
   parameter int          GEN_CYCLES  = 16,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   localparam int         X_W         = $clog2(SCREEN_W),
   localparam int         Y_W         = $clog2(SCREEN_H),
   localparam int         T_W         = $clog2(ROUND_TICKS + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_regenerate_level,
   input  logic           i_game_running,
   input  logic           i_tick,
   input  logic [X_W-1:0] i_player_x,
   input  logic [Y_W-1:0] i_player_y,
   output logic           o_ready,
   output logic           o_round_ended,
   output logic           o_is_win,
   output logic [X_W-1:0] o_zone_x,
   output logic [Y_W-1:0] o_zone_y,
   output logic [T_W-1:0] o_time_left
);

   localparam int           C_W    = $clog2(GEN_CYCLES + 1);
   localparam logic [X_W:0] X_MAX  = (X_W + 1)'(SCREEN_W - ZONE_SIZE);
   localparam logic [Y_W:0] Y_MAX  = (Y_W + 1)'(SCREEN_H - ZONE_SIZE);
   localparam logic [X_W:0] ZONE_X = (X_W + 1)'(ZONE_SIZE);
   localparam logic [Y_W:0] ZONE_Y = (Y_W + 1)'(ZONE_SIZE);

   typedef enum logic [1:0] {
      ST_GEN   = 2'd0,
      ST_RUN   = 2'd1,
      ST_ENDED = 2'd2
   } state_t;

   state_t         state;
   logic [15:0]    lfsr;
   logic [15:0]    lfsr_next;
   logic [C_W-1:0] gen_cnt;
   logic [X_W-1:0] cand_x;
   logic [Y_W-1:0] cand_y;
   logic           cand_ok;
   logic           gen_done;
   logic           tick_go;
   logic           inside_x;
   logic           inside_y;

   always_comb begin
      lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      cand_x    = lfsr[X_W-1:0];
      cand_y    = lfsr[15 -: Y_W];
      cand_ok   = ({1'b0, cand_x} <= X_MAX) && ({1'b0, cand_y} <= Y_MAX);
      gen_done  = (gen_cnt == C_W'(GEN_CYCLES));
      tick_go   = i_tick && i_game_running && (o_time_left != '0);
      // Extra top bit keeps zone_x+ZONE_SIZE from wrapping near the right edge
      inside_x  = ({1'b0, i_player_x} >= {1'b0, o_zone_x}) &&
                  ({1'b0, i_player_x} <  ({1'b0, o_zone_x} + ZONE_X));
      inside_y  = ({1'b0, i_player_y} >= {1'b0, o_zone_y}) &&
                  ({1'b0, i_player_y} <  ({1'b0, o_zone_y} + ZONE_Y));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_GEN;
         lfsr          <= LFSR_SEED;
         gen_cnt       <= '0;
         o_zone_x      <= '0;
         o_zone_y      <= '0;
         o_time_left   <= T_W'(ROUND_TICKS);
         o_ready       <= 1'b0;
         o_round_ended <= 1'b0;
         o_is_win      <= 1'b0;
      end else begin
         lfsr          <= (lfsr_next == 16'h0000) ? LFSR_SEED : lfsr_next;
         o_round_ended <= 1'b0;
         o_is_win      <= 1'b0;
         // Regenerate wins over everything, including a same-cycle expiry
         if (i_regenerate_level) begin
            state   <= ST_GEN;
            gen_cnt <= '0;
            o_ready <= 1'b0;
         end else begin
            case (state)
               ST_GEN: begin
                  if (!gen_done) begin
                     gen_cnt <= gen_cnt + C_W'(1);
                  end
                  if (gen_done && cand_ok) begin
                     o_zone_x    <= cand_x;
                     o_zone_y    <= cand_y;
                     o_time_left <= T_W'(ROUND_TICKS);
                     o_ready     <= 1'b1;
                     state       <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (tick_go) begin
                     o_time_left <= o_time_left - T_W'(1);
                     if (o_time_left == T_W'(1)) begin
                        o_round_ended <= 1'b1;
                        o_is_win      <= inside_x && inside_y;
                        state         <= ST_ENDED;
                     end
                  end
               end
               ST_ENDED: begin
                  state <= ST_ENDED;
               end
               default: begin
                  state   <= ST_GEN;
                  o_ready <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_safe_zone_round.sv
// ============================================================
// tb_safe_zone_round: randomized bench for safe_zone_round against a behavioural model
// Revision 1.0
// ============================================================
`default_nettype none

module tb_safe_zone_round;

   localparam int RT = 3;
   localparam int GC = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       regen = 1'b0;
   logic       running = 1'b0;
   logic       tick = 1'b0;
   logic [9:0] px = '0;
   logic [8:0] py = '0;
   logic       ready;
   logic       rend;
   logic       win;
   logic [9:0] zx;
   logic [8:0] zy;
   logic [1:0] tl;

   int vectors = 0;
   int errors  = 0;
   logic [9:0] zone1_x;
   logic [8:0] zone1_y;

   always #5 clk = ~clk;

   safe_zone_round #(
      .SCREEN_W   (640),
      .SCREEN_H   (480),
      .ZONE_SIZE  (64),
      .ROUND_TICKS(RT),
      .GEN_CYCLES (GC),
      .LFSR_SEED  (16'hACE1)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_regenerate_level(regen),
      .i_game_running    (running),
      .i_tick            (tick),
      .i_player_x        (px),
      .i_player_y        (py),
      .o_ready           (ready),
      .o_round_ended     (rend),
      .o_is_win          (win),
      .o_zone_x          (zx),
      .o_zone_y          (zy),
      .o_time_left       (tl)
   );

   // ---------------- behavioural reference model ----------------
   function automatic logic [15:0] step_lfsr(input logic [15:0] v);
      return 16'(v / 2) ^ ((v % 2) != 0 ? 16'hB400 : 16'h0000);
   endfunction

   function automatic bit fits(input logic [15:0] v);
      return ((int'(v) % 1024) <= 640 - 64) && ((int'(v) / 128) <= 480 - 64);
   endfunction

   function automatic bit in_zone(input int x, input int y, input int zx_, input int zy_);
      return (x >= zx_) && (x < zx_ + 64) && (y >= zy_) && (y < zy_ + 64);
   endfunction

   logic [15:0] m_lfsr;
   int          m_phase;   // 0 generating, 1 running, 2 ended
   int          m_gen;
   logic [9:0]  m_zx;
   logic [8:0]  m_zy;
   logic [1:0]  m_time;
   logic        m_end;
   logic        m_win;
   logic        m_ready;

   assign m_ready = (m_phase != 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr  <= 16'hACE1;
         m_phase <= 0;
         m_gen   <= 0;
         m_zx    <= '0;
         m_zy    <= '0;
         m_time  <= 2'(RT);
         m_end   <= 1'b0;
         m_win   <= 1'b0;
      end else begin
         m_lfsr <= step_lfsr(m_lfsr);
         m_end  <= 1'b0;
         m_win  <= 1'b0;
         if (regen) begin
            m_phase <= 0;
            m_gen   <= 0;
         end else if (m_phase == 0) begin
            if (m_gen >= GC && fits(m_lfsr)) begin
               m_zx    <= 10'(int'(m_lfsr) % 1024);
               m_zy    <= 9'(int'(m_lfsr) / 128);
               m_time  <= 2'(RT);
               m_phase <= 1;
            end else begin
               m_gen <= m_gen + 1;
            end
         end else if (m_phase == 1 && tick && running && m_time != 2'd0) begin
            m_time <= m_time - 2'd1;
            if (m_time == 2'd1) begin
               m_end   <= 1'b1;
               m_win   <= in_zone(int'(px), int'(py), int'(m_zx), int'(m_zy));
               m_phase <= 2;
            end
         end
      end
   end

   // ---------------- sequencing helpers (no comparisons beyond timeout) ----------------
   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout: o_ready=%b after %0d cycles, expected 1", name, ready, n);
      end
   endtask

   task automatic regen_level(input string name);
      tick  = 1'b0;
      regen = 1'b1;
      @(negedge clk);
      regen = 1'b0;
      wait_ready(name);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int low;
      low     = 0;
      regen   = 1'b0;
      running = 1'b0;
      tick    = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
      vectors++; if (rend  !== 1'b0) begin errors++; $display("FAIL reset_ended: got %b want 0", rend); end
      vectors++; if (win   !== 1'b0) begin errors++; $display("FAIL reset_win: got %b want 0", win); end
      vectors++; if (zx !== 10'd0 || zy !== 9'd0) begin errors++; $display("FAIL reset_zone: got (%0d,%0d) want (0,0)", zx, zy); end
      vectors++; if (tl !== 2'(RT)) begin errors++; $display("FAIL reset_time: got %0d want %0d", tl, RT); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 1000 && ready !== 1'b1; i++) begin
         vectors++;
         if (ready !== m_ready) begin errors++; $display("FAIL gen_ready cycle %0d: got %b want %b", i, ready, m_ready); end
         low++;
         @(negedge clk);
      end
      vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b want 1", ready); end
      vectors++; if (low < GC + 1) begin errors++; $display("FAIL ready_low_len: got %0d cycles want >= %0d", low, GC + 1); end
      vectors++; if (ready !== m_ready) begin errors++; $display("FAIL ready_timing: got %b want %b", ready, m_ready); end
      vectors++; if (zx > 10'd576 || zy > 9'd416) begin errors++; $display("FAIL zone_range: got (%0d,%0d) want <= (576,416)", zx, zy); end
      vectors++; if (zx !== m_zx || zy !== m_zy) begin errors++; $display("FAIL zone_value: got (%0d,%0d) want (%0d,%0d)", zx, zy, m_zx, m_zy); end
      vectors++; if (tl !== 2'(RT)) begin errors++; $display("FAIL gen_time: got %0d want %0d", tl, RT); end
      zone1_x = m_zx;
      zone1_y = m_zy;
   endtask

   task automatic test_win();
      int pulses, after;
      px = 10'(int'(zx) + 10);
      py = 9'(int'(zy) + 63);
      running = 1'b1;
      pulses = 0;
      after  = 0;
      for (int i = 0; i < 100 && after < 4; i++) begin
         tick = 1'($urandom_range(0, 1));
         @(negedge clk);
         vectors++; if (tl !== m_time) begin errors++; $display("FAIL win_time: got %0d want %0d", tl, m_time); end
         vectors++; if (rend !== m_end) begin errors++; $display("FAIL win_ended: got %b want %b", rend, m_end); end
         vectors++; if (win !== m_win) begin errors++; $display("FAIL win_flag: got %b want %b", win, m_win); end
         if (rend === 1'b1) begin
            pulses++;
            vectors++; if (win !== 1'b1) begin errors++; $display("FAIL win_verdict: got %b want 1", win); end
         end
         if (m_phase == 2) after++;
      end
      tick = 1'b0;
      vectors++; if (pulses != 1) begin errors++; $display("FAIL win_pulses: got %0d want 1", pulses); end
      vectors++; if (tl !== 2'd0) begin errors++; $display("FAIL win_ended_time: got %0d want 0", tl); end
   endtask

   task automatic test_loss();
      int pulses, after;
      regen_level("loss");
      px = 10'(int'(m_zx) + 64);
      py = 9'(m_zy);
      running = 1'b1;
      pulses = 0;
      after  = 0;
      for (int i = 0; i < 100 && after < 3; i++) begin
         tick = 1'($urandom_range(0, 1));
         @(negedge clk);
         vectors++; if (tl !== m_time) begin errors++; $display("FAIL loss_time: got %0d want %0d", tl, m_time); end
         vectors++; if (rend !== m_end) begin errors++; $display("FAIL loss_ended: got %b want %b", rend, m_end); end
         vectors++; if (win !== 1'b0) begin errors++; $display("FAIL loss_flag: got %b want 0", win); end
         if (rend === 1'b1) pulses++;
         if (m_phase == 2) after++;
      end
      tick = 1'b0;
      vectors++; if (pulses != 1) begin errors++; $display("FAIL loss_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_pause();
      int pulses;
      regen_level("pause");
      px = 10'($urandom_range(0, 639));
      py = 9'($urandom_range(0, 479));
      running = 1'b1;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      vectors++; if (tl !== 2'd2) begin errors++; $display("FAIL pause_first_tick: got %0d want 2", tl); end
      running = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick = (i % 2 == 0);
         @(negedge clk);
         vectors++; if (tl !== 2'd2) begin errors++; $display("FAIL pause_hold: got %0d want 2", tl); end
         vectors++; if (rend !== 1'b0) begin errors++; $display("FAIL pause_ended: got %b want 0", rend); end
      end
      running = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick = (i < 2);
         @(negedge clk);
         vectors++; if (tl !== m_time) begin errors++; $display("FAIL resume_time: got %0d want %0d", tl, m_time); end
         vectors++; if (win !== m_win) begin errors++; $display("FAIL resume_win: got %b want %b", win, m_win); end
         if (rend === 1'b1) begin
            pulses++;
            vectors++;
            if (win !== in_zone(int'(px), int'(py), int'(m_zx), int'(m_zy))) begin
               errors++; $display("FAIL resume_verdict: got %b want %b", win, in_zone(int'(px), int'(py), int'(m_zx), int'(m_zy)));
            end
         end
      end
      tick = 1'b0;
      vectors++; if (pulses != 1) begin errors++; $display("FAIL resume_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_random();
      int pulses, after;
      for (int r = 0; r < 6; r++) begin
         regen_level("random");
         vectors++; if (zx !== m_zx || zy !== m_zy) begin errors++; $display("FAIL rand_zone: got (%0d,%0d) want (%0d,%0d)", zx, zy, m_zx, m_zy); end
         if ($urandom_range(0, 1) == 1) begin
            px = 10'(int'(m_zx) + int'($urandom_range(0, 63)));
            py = 9'(int'(m_zy) + int'($urandom_range(0, 63)));
         end else begin
            px = 10'($urandom_range(0, 639));
            py = 9'($urandom_range(0, 479));
         end
         pulses = 0;
         after  = 0;
         for (int i = 0; i < 200 && after < 3; i++) begin
            tick    = 1'($urandom_range(0, 1));
            running = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            vectors++; if (tl !== m_time) begin errors++; $display("FAIL rand_time: got %0d want %0d", tl, m_time); end
            vectors++; if (rend !== m_end) begin errors++; $display("FAIL rand_ended: got %b want %b", rend, m_end); end
            vectors++; if (win !== m_win) begin errors++; $display("FAIL rand_win: got %b want %b", win, m_win); end
            if (rend === 1'b1) pulses++;
            if (m_phase == 2) after++;
         end
         tick = 1'b0;
         vectors++; if (pulses != 1) begin errors++; $display("FAIL rand_pulses: got %0d want 1", pulses); end
      end
   endtask

   task automatic test_regen_collision();
      regen_level("collision");
      px = m_zx;
      py = m_zy;
      running = 1'b1;
      for (int i = 0; i < 50 && m_time != 2'd1; i++) begin
         tick = 1'b1;
         @(negedge clk);
      end
      tick  = 1'b1;
      regen = 1'b1;
      @(negedge clk);
      tick  = 1'b0;
      regen = 1'b0;
      vectors++; if (rend !== 1'b0) begin errors++; $display("FAIL collide_ended: got %b want 0", rend); end
      vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL collide_ready: got %b want 0", ready); end
      vectors++; if (win !== 1'b0) begin errors++; $display("FAIL collide_win: got %b want 0", win); end
      wait_ready("collision");
      vectors++; if (tl !== 2'(RT)) begin errors++; $display("FAIL collide_time: got %0d want %0d", tl, RT); end
      vectors++; if (zx !== m_zx || zy !== m_zy) begin errors++; $display("FAIL collide_zone: got (%0d,%0d) want (%0d,%0d)", zx, zy, m_zx, m_zy); end
      vectors++; if (ready !== m_ready) begin errors++; $display("FAIL collide_ready_timing: got %b want %b", ready, m_ready); end
   endtask

   task automatic test_abort();
      regen_level("abort");
      running = 1'b1;
      for (int i = 0; i < 50 && m_time != 2'd1; i++) begin
         tick = 1'b1;
         @(negedge clk);
      end
      tick = 1'b0;
      vectors++; if (tl !== 2'd1) begin errors++; $display("FAIL abort_pre_time: got %0d want 1", tl); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", ready); end
      vectors++; if (rend !== 1'b0) begin errors++; $display("FAIL abort_ended: got %b want 0", rend); end
      vectors++; if (zx !== 10'd0 || zy !== 9'd0) begin errors++; $display("FAIL abort_zone: got (%0d,%0d) want (0,0)", zx, zy); end
      vectors++; if (tl !== 2'(RT)) begin errors++; $display("FAIL abort_time: got %0d want %0d", tl, RT); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready("abort");
      vectors++; if (zx !== zone1_x || zy !== zone1_y) begin errors++; $display("FAIL abort_same_zone: got (%0d,%0d) want (%0d,%0d)", zx, zy, zone1_x, zone1_y); end
      vectors++; if (zx !== m_zx || zy !== m_zy) begin errors++; $display("FAIL abort_zone_model: got (%0d,%0d) want (%0d,%0d)", zx, zy, m_zx, m_zy); end
   endtask

   initial begin
      test_reset();
      test_win();
      test_loss();
      test_pause();
      test_random();
      test_regen_collision();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
